// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall-bus codes, multi-cycle FSM encodings and reset polarity for the
// pipeline stall/flush scheduler.
package pipe_stall_ctrl_pkg;

   localparam int STALLBUS_W = 6;

   // Hold masks: bit 0 = pc ... bit 5 = wb; a stall freezes its stage and all upstream
   localparam logic [STALLBUS_W-1:0] STALL_NONE = 6'b000000;
   localparam logic [STALLBUS_W-1:0] STALL_IF   = 6'b000011;
   localparam logic [STALLBUS_W-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALLBUS_W-1:0] STALL_EX   = 6'b001111;

   typedef enum logic [1:0] {
      MC_IDLE = 2'd0,
      MC_BUSY = 2'd1,
      MC_DONE = 2'd2
   } mc_state_e;

   localparam logic RSTENABLE_N = 1'b0;

endpackage

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler: prioritises fetch/decode/execute stall requests,
// sequences multi-cycle execute ops and counts stalled cycles.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int MC_W   = 6,
   parameter int PERF_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stallreq_if_i,
   input  logic                  stallreq_id_i,
   input  logic                  mc_start_i,
   input  logic [MC_W-1:0]       mc_cycles_i,
   input  logic                  flush_i,
   output logic [STALLBUS_W-1:0] stall_o,
   output logic                  flush_o,
   output logic                  mc_busy_o,
   output logic                  mc_done_o,
   output logic [PERF_W-1:0]     stall_cnt_o
);

   mc_state_e             state_reg, state_next;
   logic [MC_W-1:0]       cnt_reg, cnt_next;
   logic [PERF_W-1:0]     perf_reg;
   logic [MC_W-1:0]       n_eff;
   logic                  ex_stall;
   logic                  in_reset;

   assign in_reset = (rst == RSTENABLE_N);

   // A zero-length request still costs one execute cycle
   assign n_eff    = (mc_cycles_i == '0) ? MC_W'(1) : mc_cycles_i;
   assign ex_stall = ((state_reg == MC_IDLE) && mc_start_i) || (state_reg == MC_BUSY);

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RSTENABLE_N) begin
         state_reg <= MC_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (flush_i) begin
         state_next = MC_IDLE;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            MC_IDLE: begin
               if (mc_start_i) begin
                  if (n_eff == MC_W'(1)) begin
                     state_next = MC_DONE;
                  end else begin
                     state_next = MC_BUSY;
                     cnt_next   = n_eff - MC_W'(2);
                  end
               end
            end
            MC_BUSY: begin
               if (cnt_reg == '0) begin
                  state_next = MC_DONE;
               end else begin
                  cnt_next = cnt_reg - MC_W'(1);
               end
            end
            MC_DONE: state_next = MC_IDLE;
            default: begin
               state_next = MC_IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_comb begin
      stall_o   = STALL_NONE;
      flush_o   = 1'b0;
      mc_busy_o = 1'b0;
      mc_done_o = 1'b0;
      if (!in_reset) begin
         flush_o   = flush_i;
         mc_busy_o = (state_reg == MC_BUSY);
         mc_done_o = (state_reg == MC_DONE);
         if (flush_i) begin
            stall_o = STALL_NONE;
         end else if (ex_stall) begin
            stall_o = STALL_EX;
         end else if (stallreq_id_i) begin
            stall_o = STALL_ID;
         end else if (stallreq_if_i) begin
            stall_o = STALL_IF;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RSTENABLE_N) begin
         perf_reg <= '0;
      end else if ((stall_o != STALL_NONE) && (perf_reg != {PERF_W{1'b1}})) begin
         perf_reg <= perf_reg + PERF_W'(1);
      end
   end

   assign stall_cnt_o = perf_reg;

endmodule
